// File: rtl/xor_unit_arbiter.sv
// Round-robin scheduler sharing one pipelined XOR unit among NREQ requesters.
// Define XARB_CHECK_EN to add the sticky err output flagging unit latency mismatches.
module xor_unit_arbiter #(
  parameter int W    = 10,
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  input  logic              hold,
  output logic              idle,
  output logic              unit_start,
  output logic [W-1:0]      unit_a,
  output logic [W-1:0]      unit_b,
  input  logic [W-1:0]      unit_y,
  input  logic              unit_valid
`ifdef XARB_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            rr_q, rr_d;
  logic [NREQ-1:0]          gnt_q, gnt_d;
  logic                     unit_start_q, unit_start_d;
  logic [W-1:0]             unit_a_q, unit_a_d;
  logic [W-1:0]             unit_b_q, unit_b_d;
  logic [IW-1:0]            issue_idx_q, issue_idx_d;
  logic [LAT-1:0]           tag_vld_q;
  logic [LAT-1:0][IW-1:0]   tag_idx_q;

  logic [NREQ-1:0]          eligible;
  logic [IW:0]              cand;
  logic [IW-1:0]            win_idx;
  logic                     found;
  logic                     issue;
  logic                     tag_busy;

  // A requester granted last cycle sits out one edge so it can drop or refresh its operands.
  assign eligible = req & ~gnt_q;

  always_comb begin
    cand    = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && eligible[cand[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  // Drain completes once only the retiring output stage may still hold a tag.
  always_comb begin
    tag_busy = 1'b0;
    for (int i = 0; i < LAT - 1; i++) tag_busy = tag_busy | tag_vld_q[i];
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!hold && found) begin
          state_d = ST_RUN;
          issue   = 1'b1;
        end
      end
      ST_RUN: begin
        if (hold) state_d = ST_DRAIN;
        else      issue   = found;
      end
      ST_DRAIN: begin
        if (!hold)          state_d = ST_RUN;
        else if (!tag_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d        = '0;
    unit_start_d = 1'b0;
    unit_a_d     = unit_a_q;
    unit_b_d     = unit_b_q;
    rr_d         = rr_q;
    issue_idx_d  = issue_idx_q;
    if (issue) begin
      gnt_d        = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
      unit_start_d = 1'b1;
      unit_a_d     = a_in[win_idx*W +: W];
      unit_b_d     = b_in[win_idx*W +: W];
      rr_d         = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      issue_idx_d  = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      unit_start_q <= 1'b0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      issue_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      unit_start_q <= unit_start_d;
      unit_a_q     <= unit_a_d;
      unit_b_q     <= unit_b_d;
      issue_idx_q  <= issue_idx_d;
    end
  end

  // Stage 0 captures the tag as the unit samples start; the last stage lines up with unit_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      tag_vld_q[0] <= unit_start_q;
      tag_idx_q[0] <= issue_idx_q;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = unit_valid & tag_vld_q[LAT-1] & (tag_idx_q[LAT-1] == IW'(gi));
  end

  assign rsp_data   = unit_y;
  assign gnt        = gnt_q;
  assign unit_start = unit_start_q;
  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign idle       = (state_q == ST_IDLE);

`ifdef XARB_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)                                  err_q <= 1'b0;
    else if (unit_valid != tag_vld_q[LAT-1])  err_q <= 1'b1;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Directed bench for xor_unit_arbiter with a behavioural two-stage XOR unit model.
// Covers reset, single issue, wrap, fairness, drain and the optional XARB_CHECK_EN err flag.
module tb_xor_unit_arbiter;
  localparam int W    = 10;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in, b_in;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              hold, idle, unit_start;
  logic [W-1:0]      unit_a, unit_b, unit_y;
  logic              unit_valid;
  logic              inj_valid;
`ifdef XARB_CHECK_EN
  logic              err;
`endif

  // XOR unit: registers start/a/b, then presents y/valid one cycle later.
  logic         m_s1 = 1'b0, m_v = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0, m_y = '0;

  always @(posedge clk) begin
    m_s1 <= unit_start;
    m_a  <= unit_a;
    m_b  <= unit_b;
    m_v  <= m_s1;
    m_y  <= m_a ^ m_b;
  end

  assign unit_valid = m_v | inj_valid;
  assign unit_y     = m_y;

  always #5 clk = ~clk;

  xor_unit_arbiter #(.W(W), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .hold       (hold),
    .idle       (idle),
    .unit_start (unit_start),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .unit_y     (unit_y),
    .unit_valid (unit_valid)
`ifdef XARB_CHECK_EN
    ,
    .err        (err)
`endif
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[k*W +: W] = a;
    b_in[k*W +: W] = b;
  endtask

  logic [W-1:0] fa [8];
  logic [W-1:0] fb [8];
  logic [W-1:0] fy [8];
  int           pulse_cnt [NREQ];

  initial begin
    fa = '{10'h001, 10'h0F0, 10'h3FF, 10'h2AA, 10'h123, 10'h00F, 10'h200, 10'h3C3};
    fb = '{10'h100, 10'h00F, 10'h3FF, 10'h155, 10'h321, 10'h0FF, 10'h001, 10'h0C3};
    fy = '{10'h101, 10'h0FF, 10'h000, 10'h3FF, 10'h202, 10'h0F0, 10'h201, 10'h300};

    rst = 1'b1; req = '0; a_in = '0; b_in = '0; hold = 1'b0; inj_valid = 1'b0;
    tick(); tick();
    check_eq("rst_gnt",        32'(gnt), 32'h0);
    check_eq("rst_unit_start", 32'(unit_start), 32'h0);
    check_eq("rst_unit_a",     32'(unit_a), 32'h0);
    check_eq("rst_unit_b",     32'(unit_b), 32'h0);
    check_eq("rst_idle",       32'(idle), 32'h1);
    check_eq("rst_rsp_valid",  32'(rsp_valid), 32'h0);
    rst = 1'b0;

    // single request on requester 2
    set_ops(2, 10'h3FF, 10'h155);
    req = 4'b0100;
    tick();
    check_eq("single_gnt",        32'(gnt), 32'h4);
    check_eq("single_unit_start", 32'(unit_start), 32'h1);
    check_eq("single_unit_a",     32'(unit_a), 32'h3FF);
    check_eq("single_unit_b",     32'(unit_b), 32'h155);
    check_eq("single_idle",       32'(idle), 32'h0);
    req = '0;
    tick();
    check_eq("single_gnt_drop",   32'(gnt), 32'h0);
    check_eq("single_rsp_early",  32'(rsp_valid), 32'h0);
    tick();
    check_eq("single_rsp_valid",  32'(rsp_valid), 32'h4);
    check_eq("single_rsp_data",   32'(rsp_data), 32'h2AA);

    // wrap: pointer now 3, requesters 0 and 1
    set_ops(0, 10'h055, 10'h0AA);
    set_ops(1, 10'h3F0, 10'h00F);
    req = 4'b0011;
    tick();
    check_eq("wrap_gnt0", 32'(gnt), 32'h1);
    req = 4'b0010;
    tick();
    check_eq("wrap_gnt1", 32'(gnt), 32'h2);
    req = '0;
    tick();
    check_eq("wrap_gnt_none",  32'(gnt), 32'h0);
    check_eq("wrap_rsp0",      32'(rsp_valid), 32'h1);
    check_eq("wrap_rsp0_data", 32'(rsp_data), 32'h0FF);
    req = 4'b1111;
    tick();
    check_eq("wrap_ptr2_gnt",  32'(gnt), 32'h4);
    check_eq("wrap_rsp1",      32'(rsp_valid), 32'h2);
    check_eq("wrap_rsp1_data", 32'(rsp_data), 32'h3FF);

    // reset with a result still in flight
    rst = 1'b1; req = '0;
    tick();
    check_eq("midrst_gnt",        32'(gnt), 32'h0);
    check_eq("midrst_unit_start", 32'(unit_start), 32'h0);
    check_eq("midrst_unit_a",     32'(unit_a), 32'h0);
    check_eq("midrst_unit_b",     32'(unit_b), 32'h0);
    check_eq("midrst_idle",       32'(idle), 32'h1);
    check_eq("midrst_rsp_valid",  32'(rsp_valid), 32'h0);
    tick();
    check_eq("midrst_stale_rsp",  32'(rsp_valid), 32'h0);
    rst = 1'b0;
    inj_valid = 1'b1;
    tick();
    check_eq("spurious_rsp",      32'(rsp_valid), 32'h0);
    inj_valid = 1'b0;
    tick();
`ifdef XARB_CHECK_EN
    check_eq("err_set",    32'(err), 32'h1);
`endif
    tick();
`ifdef XARB_CHECK_EN
    check_eq("err_sticky", 32'(err), 32'h1);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef XARB_CHECK_EN
    check_eq("err_cleared", 32'(err), 32'h0);
`endif

    // fairness: all four requesting, operands refreshed after each grant
    for (int k = 0; k < NREQ; k++) begin
      set_ops(k, fa[k], fb[k]);
      pulse_cnt[k] = 0;
    end
    req = 4'b1111;
    for (int t = 0; t < 11; t++) begin
      tick();
      if (t < 8) begin
        check_eq($sformatf("fair_gnt_%0d", t),    32'(gnt), 32'(1 << (t % 4)));
        check_eq($sformatf("fair_a_%0d", t),      32'(unit_a), 32'(fa[t]));
        check_eq($sformatf("fair_b_%0d", t),      32'(unit_b), 32'(fb[t]));
        if (t < 4) set_ops(t, fa[t+4], fb[t+4]);
        if (t == 7) req = '0;
      end else begin
        check_eq($sformatf("fair_gnt_%0d", t),    32'(gnt), 32'h0);
      end
      if (t >= 2 && t < 10) begin
        check_eq($sformatf("fair_rsp_%0d", t),    32'(rsp_valid), 32'(1 << ((t - 2) % 4)));
        check_eq($sformatf("fair_data_%0d", t),   32'(rsp_data), 32'(fy[t-2]));
      end else begin
        check_eq($sformatf("fair_rsp_%0d", t),    32'(rsp_valid), 32'h0);
      end
      for (int k = 0; k < NREQ; k++) if (rsp_valid[k]) pulse_cnt[k]++;
    end
    for (int k = 0; k < NREQ; k++)
      check_eq($sformatf("fair_pulses_%0d", k), 32'(pulse_cnt[k]), 32'd2);

    // drain: hold with two results in flight
    set_ops(0, 10'h111, 10'h222);
    set_ops(1, 10'h0AA, 10'h055);
    req = 4'b0011;
    tick();
    check_eq("drain_gnt0", 32'(gnt), 32'h1);
    req = 4'b0010;
    tick();
    check_eq("drain_gnt1", 32'(gnt), 32'h2);
    hold = 1'b1;
    req  = 4'b0100;
    tick();
    check_eq("drain_no_start0", 32'(unit_start), 32'h0);
    check_eq("drain_no_gnt",    32'(gnt), 32'h0);
    check_eq("drain_rsp0",      32'(rsp_valid), 32'h1);
    check_eq("drain_rsp0_data", 32'(rsp_data), 32'h333);
    check_eq("drain_busy0",     32'(idle), 32'h0);
    tick();
    check_eq("drain_no_start1", 32'(unit_start), 32'h0);
    check_eq("drain_rsp1",      32'(rsp_valid), 32'h2);
    check_eq("drain_rsp1_data", 32'(rsp_data), 32'h0FF);
    check_eq("drain_busy1",     32'(idle), 32'h0);
    tick();
    check_eq("drain_idle",      32'(idle), 32'h1);
    check_eq("drain_rsp_done",  32'(rsp_valid), 32'h0);
    tick();
    check_eq("hold_idle_stay",  32'(idle), 32'h1);
    check_eq("hold_idle_gnt",   32'(gnt), 32'h0);
    hold = 1'b0;
    tick();
    check_eq("resume_gnt",      32'(gnt), 32'h4);
    check_eq("resume_unit_a",   32'(unit_a), 32'h200);
    check_eq("resume_unit_b",   32'(unit_b), 32'h001);
    check_eq("resume_idle",     32'(idle), 32'h0);
    req = '0;
    tick();
    tick();
    check_eq("resume_rsp",      32'(rsp_valid), 32'h4);
    check_eq("resume_rsp_data", 32'(rsp_data), 32'h201);
`ifdef XARB_CHECK_EN
    check_eq("err_clean_traffic", 32'(err), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/xor_unit_arbiter.md
Name: xor_unit_arbiter

Overview:
- Round-robin scheduler that shares one pipelined two-operand XOR unit among NREQ requesters.
- The XOR unit registers start/a/b once, then produces y/valid one cycle later.
- This block selects one requester per cycle, drives the unit's start/a/b, and tracks an issue tag through the unit latency.
- It routes the unit's y/valid back to the originating requester; hold/drain control allows the unit to be quiesced.

Parameters:
- W, 10, operand/result width.
- NREQ, 4, number of requesters (2..8).
- LAT, 2, cycles from unit_start high to unit_valid high.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; operands must be stable while high.
- a_in  in  NREQ*W  packed operand A; slice k = a_in[k*W +: W].
- b_in  in  NREQ*W  packed operand B, same packing.
- gnt  out  NREQ  one-hot, registered, one-cycle grant pulse.
- rsp_valid  out  NREQ  one-hot result strobe to the owning requester.
- rsp_data  out  W  result data, meaningful when any rsp_valid bit is high.
- hold  in  1  stop issuing and drain the unit.
- idle  out  1  high in IDLE state.
- unit_start  out  1  start strobe to the XOR unit.
- unit_a  out  W  operand A to the XOR unit.
- unit_b  out  W  operand B to the XOR unit.
- unit_y  in  W  result from the XOR unit.
- unit_valid  in  1  result valid from the XOR unit.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - state=IDLE, rr pointer=0, tag pipeline cleared (all slots invalid).
  - gnt=0, unit_start=0, unit_a=0, unit_b=0, idle=1.
- Reset mid-operation discards in-flight tags. rsp_valid is suppressed for LAT cycles after reset, even if unit_valid arrives.
- States:
  - IDLE: no issue. Go to RUN when hold=0 and req masked by current gnt is non-zero.
  - RUN: issue at most one request per cycle. Go to DRAIN when hold=1.
  - DRAIN: no issue. Go to IDLE when the tag pipeline is empty and hold=1; go to RUN if hold drops before then.
  - In IDLE with hold=1, stay in IDLE.
- Arbitration, in RUN (or an IDLE→RUN edge):
  - eligible = req & ~gnt; a requester being granted this cycle is ignored for one edge.
  - Winner = first eligible index at or after the rr pointer, wrapping modulo NREQ.
  - At the clock edge: gnt[winner]<=1, unit_start<=1, unit_a/unit_b <= winner's slices, rr pointer <= winner+1 (mod NREQ).
  - With no eligible request, or not issuing: gnt<=0, unit_start<=0, unit_a/unit_b hold their previous values.
- Requester rule:
  - Deassert req in the cycle gnt is high, or re-present new operands to be re-eligible next cycle.
  - Arbiter throughput: one grant per cycle; the same requester can win at most every other cycle.
- Tag tracking:
  - A shift register of LAT stages holds {valid, index}; stage 0 is loaded alongside unit_start.
  - The output stage aligns with unit_valid.
- Response routing (combinational):
  - rsp_valid[k] = unit_valid & tag_out.valid & (tag_out.index==k).
  - rsp_data = unit_y.
- Latency: req sampled at edge E → gnt/unit_start high cycle E+1 → rsp_valid high cycle E+1+LAT.
- No backpressure: the unit is fully pipelined and the requester must accept rsp_valid.
- Single requester, continuous req held: grants every other cycle.
- All NREQ requesting continuously: grants rotate 0,1,2,3,0...; no requester is starved beyond NREQ cycles.
- hold asserted in the same cycle as a would-be issue: no issue. In-flight results still return.

Optional Feature:
- Macro XARB_CHECK_EN.
- When defined:
  - Adds output err (1 bit, reset 0, sticky until rst).
  - err sets when unit_valid=1 with tag_out invalid, or unit_valid=0 with tag_out valid (a latency mismatch).
- When undefined: no err port, no check logic; unit_valid without a tag is silently ignored.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic → all outputs zero, idle=1; a unit_valid arriving 1 cycle after reset produces no rsp_valid.
- Single request: req[2]=1, a=0x3FF, b=0x155 → gnt[2] next cycle, unit_a=0x3FF, unit_b=0x155; rsp_valid[2] with rsp_data=0x2AA LAT cycles later.
- Fairness: req=4'b1111 held 8 cycles (operands changed after each grant) → grant order 0,1,2,3,0,1,2,3; each rsp_valid bit pulses exactly twice.
- Wrap: pointer at 3, req=4'b0011 → gnt[0] then gnt[1]; pointer ends at 2.
- Drain: hold=1 while 2 results in flight → no new unit_start; both responses delivered; idle=1 the cycle after the last unit_valid; hold=0 resumes with gnt next cycle.
- XARB_CHECK_EN: inject spurious unit_valid with empty pipeline → err=1 and it stays 1 until rst.
